// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] SRCA,
  input  logic [DATA_WIDTH-1:0] SRCB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_in, op_q;
  logic          neg_q;
  logic [W-1:0]  mcand_q;
  logic [2*W-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  result_q;

  logic          signed_a, signed_b, a_neg, b_neg, res_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic          div_zero, div_ovf, special;
  logic [W-1:0]  special_res;

  logic [W:0]    mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]    div_shift, div_diff;
  logic          div_ge;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod;
  logic [W-1:0]  div_sel, sign_word;

  // Operand conditioning at launch: magnitudes plus one stored result sign.
  always_comb begin
    op_in    = muldiv_op_e'(op);
    signed_a = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    signed_b = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg    = signed_a & SRCA[W-1];
    b_neg    = signed_b & SRCB[W-1];
    a_mag    = a_neg ? (~SRCA + ONE) : SRCA;
    b_mag    = b_neg ? (~SRCB + ONE) : SRCB;
    res_neg  = (is_div(op_in) && op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div(op_in) && (SRCB == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (SRCA == SMIN) && (SRCB == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = op[1] ? SRCA : '1;
    else          special_res = op[1] ? '0 : SMIN;
  end

  // Per-step datapath; acc holds {hi:lo} = {product high : multiplier} or {remainder : quotient}.
  always_comb begin
    mul_sum   = acc_q[0] ? ({1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q}) : {1'b0, acc_q[2*W-1:W]};
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = acc_q[2*W-1:W-1];
    div_ge    = div_shift >= {1'b0, mcand_q};
    div_diff  = div_shift - {1'b0, mcand_q};
    div_next  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
    prod      = neg_q ? (~acc_q + (2*W)'(1)) : acc_q;
    div_sel   = op_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
    if (is_div(op_q))        sign_word = neg_q ? (~div_sel + ONE) : div_sel;
    else if (op_q == OP_MUL) sign_word = prod[W-1:0];
    else                     sign_word = prod[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_d = special ? DONE : CALC;
        CALC: if (cnt_q == '0) state_d = SIGN;
        SIGN: state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == CALC) || (state_q == SIGN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (!flush) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op_in;
            neg_q   <= res_neg;
            cnt_q   <= CW'(W - 1);
            mcand_q <= is_div(op_in) ? b_mag : a_mag;
            acc_q   <= {{W{1'b0}}, (is_div(op_in) ? a_mag : b_mag)};
            if (special) result_q <= special_res;
          end
        end
        CALC: begin
          acc_q <= is_div(op_q) ? div_next : mul_next;
          cnt_q <= cnt_q - CW'(1);
        end
        SIGN: result_q <= sign_word;
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer with a plain-arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] srca = '0;
  logic [W-1:0] srcb = '0;
  logic         busy, done;
  logic [W-1:0] result;

  muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .SRCA(srca), .SRCB(srcb), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          tag;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_exp = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb2, ub, p;
    longint unsigned up;
    int              ia, ib;
    sa  = $signed(a);
    sb2 = $signed(b);
    ub  = b;
    ia  = $signed(a);
    ib  = $signed(b);
    case (o)
      3'b000: begin up = longint'(a) * longint'(b); return up[31:0]; end
      3'b001: begin p = sa * sb2; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin up = longint'(a) * longint'(b); return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'b100 || o == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return W + 2;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("latency", 32'(cyc - e.tag), 32'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !busy && !done) return;
      @(negedge clk); #1;
    end
    chk("idle_timeout", 32'd1, 32'd0);
    sb.delete();
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    op = o; srca = a; srcb = b; start = 1'b1;
    e.res = ref_model(o, a, b);
    e.tag = cyc;
    e.lat = ref_lat(o, a, b);
    last_exp = e.res;
    sb.push_back(e);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prior;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Busy/done timing of a plain multiply.
    issue(OP_MUL, 32'd7, 32'd6);
    for (int i = 1; i <= 34; i++) begin
      chk("busy_window", 32'(busy), 32'(i <= 33));
      chk("done_window", 32'(done), 32'(i == 34));
      @(negedge clk); #1;
    end

    issue(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(OP_MULHSU, 32'hFFFFFFFF, 32'd2);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    issue(OP_REM, 32'hFFFFFFF9, 32'd2);
    issue(OP_DIVU, 32'd100, 32'd7);
    issue(OP_REMU, 32'd100, 32'd7);
    issue(OP_DIVU, 32'd5, 32'd0);
    issue(OP_REM, 32'd5, 32'd0);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    issue(OP_REM, 32'h80000000, 32'hFFFFFFFF);

    // A start pulse mid-operation must be ignored.
    issue(OP_MUL, 32'd1234, 32'd5678);
    repeat (4) begin @(negedge clk); #1; end
    op = OP_DIVU; srca = 32'd99; srcb = 32'd3; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Flush: no done, result retained.
    prior = last_exp;
    issue(OP_MULHU, 32'hDEADBEEF, 32'h12345678);
    repeat (9) begin @(negedge clk); #1; end
    flush = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    void'(sb.pop_back());
    repeat (40) begin
      chk("flush_done", 32'(done), 32'd0);
      @(negedge clk); #1;
    end
    chk("flush_result", result, prior);

    // Asynchronous reset mid-calculation.
    issue(OP_DIVU, 32'hCAFEF00D, 32'd13);
    repeat (10) begin @(negedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", result, 32'd0);
    sb.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    issue(OP_MULH, 32'h80000000, 32'h7FFFFFFF);

    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
